// File: rtl/tug_referee_pkg.sv
// Tug-of-war referee shared definitions.
// Holds the FSM states, the rope and score limits, and the LED helper.
package tug_referee_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    ROUND_END = 2'd1,
    GAME_OVER = 2'd2
  } state_e;

  localparam logic [3:0] CENTER     = 4'd4;
  localparam logic [3:0] MAX_POS    = 4'd8;
  localparam logic [1:0] WIN_SCORE  = 2'd3;
  localparam int         ROUND_HOLD = 16;
  localparam int         FLASH_DIV  = 8;

  function automatic logic [8:0] onehot(
    input logic [3:0] p
  );
    return 9'd1 << p;
  endfunction

endpackage

// File: rtl/tug_referee_if.sv
// Tug-of-war player and display bundle.
// master drives slowen/push/right; slave drives pos, leds, pulses, scores, rwon.
interface tug_if;
  logic       slowen;
  logic       push;
  logic       right;
  logic [3:0] pos;
  logic [8:0] leds;
  logic       winrnd;
  logic       wingame;
  logic [1:0] lscore;
  logic [1:0] rscore;
  logic       rwon;

  modport master (
    output slowen, push, right,
    input  pos, leds, winrnd, wingame,
    input  lscore, rscore, rwon
  );

  modport slave (
    input  slowen, push, right,
    output pos, leds, winrnd, wingame,
    output lscore, rscore, rwon
  );
endinterface

// File: rtl/tug_referee_hold_timer.sv
// Counts slowen pulses up to TERM; o_done pulses combinationally on the TERM-th.
// Ports: clk, rst, i_clr (hold at zero), i_en (slowen), o_done.
module tug_hold_timer #(
  parameter int TERM = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam int W = $clog2(TERM);

  logic [W-1:0] r_cnt;

  assign o_done = i_en && !i_clr &&
                  (r_cnt == W'(TERM - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr || o_done) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tug_referee.sv
// Tug-of-war referee: rope position, round/game scoring, LED display.
// Ports: clk, rst (sync, active-high), bus (tug_if.slave).
module tug_referee
  import tug_referee_pkg::*;
(
  input logic clk,
  input logic rst,
  tug_if.slave bus
);

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_pos;
  logic [3:0] w_pos_nxt;
  logic [1:0] r_lscore;
  logic [1:0] w_lscore_nxt;
  logic [1:0] r_rscore;
  logic [1:0] w_rscore_nxt;
  logic       r_rwon;
  logic       w_rwon_nxt;
  logic       r_winrnd;
  logic       w_winrnd_nxt;
  logic       r_wingame;
  logic       w_wingame_nxt;
  logic       r_flash;
  logic       w_flash_nxt;
  logic [1:0] w_own_score;
  logic       w_hold_done;
  logic       w_flash_done;
  logic [8:0] w_leds;

  tug_hold_timer #(
    .TERM (ROUND_HOLD)
  ) u_hold (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state != ROUND_END),
    .i_en   (bus.slowen),
    .o_done (w_hold_done)
  );

  tug_hold_timer #(
    .TERM (FLASH_DIV)
  ) u_flash (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state != GAME_OVER),
    .i_en   (bus.slowen),
    .o_done (w_flash_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= PLAY;
      r_pos     <= CENTER;
      r_lscore  <= '0;
      r_rscore  <= '0;
      r_rwon    <= 1'b0;
      r_winrnd  <= 1'b0;
      r_wingame <= 1'b0;
      r_flash   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_pos     <= w_pos_nxt;
      r_lscore  <= w_lscore_nxt;
      r_rscore  <= w_rscore_nxt;
      r_rwon    <= w_rwon_nxt;
      r_winrnd  <= w_winrnd_nxt;
      r_wingame <= w_wingame_nxt;
      r_flash   <= w_flash_nxt;
    end
  end

  assign w_own_score = bus.right ? r_rscore
                                 : r_lscore;

  always_comb begin
    w_state_nxt   = r_state;
    w_pos_nxt     = r_pos;
    w_lscore_nxt  = r_lscore;
    w_rscore_nxt  = r_rscore;
    w_rwon_nxt    = r_rwon;
    w_winrnd_nxt  = 1'b0;
    w_wingame_nxt = 1'b0;
    w_flash_nxt   = r_flash;
    unique case (r_state)
      PLAY: begin
        if (bus.push && r_pos >= 4'd1 &&
            r_pos <= 4'd7) begin
          w_pos_nxt = bus.right ? r_pos + 4'd1
                                : r_pos - 4'd1;
          if (w_pos_nxt == MAX_POS ||
              w_pos_nxt == 4'd0) begin
            w_rwon_nxt = bus.right;
            if (bus.right) begin
              w_rscore_nxt = r_rscore + 2'd1;
            end else begin
              w_lscore_nxt = r_lscore + 2'd1;
            end
            // Winner had WIN_SCORE-1: this win ends the game.
            if (w_own_score == WIN_SCORE - 2'd1) begin
              w_state_nxt   = GAME_OVER;
              w_wingame_nxt = 1'b1;
              w_flash_nxt   = 1'b1;
            end else begin
              w_state_nxt  = ROUND_END;
              w_winrnd_nxt = 1'b1;
            end
          end
        end
      end
      ROUND_END: begin
        if (w_hold_done) begin
          w_pos_nxt   = CENTER;
          w_state_nxt = PLAY;
        end
      end
      GAME_OVER: begin
        if (w_flash_done) begin
          w_flash_nxt = ~r_flash;
        end
      end
      default: begin
        w_state_nxt = PLAY;
      end
    endcase
  end

  always_comb begin
    w_leds = onehot(r_pos);
    if (r_state == GAME_OVER) begin
      w_leds = '0;
      if (r_flash) begin
        w_leds = r_rwon ? 9'h100 : 9'h001;
      end
    end
  end

  assign bus.pos     = r_pos;
  assign bus.leds    = w_leds;
  assign bus.winrnd  = r_winrnd;
  assign bus.wingame = r_wingame;
  assign bus.lscore  = r_lscore;
  assign bus.rscore  = r_rscore;
  assign bus.rwon    = r_rwon;

endmodule

// File: doc/tug_referee.md
TUG_REFEREE -- requirements
Module: tug_referee

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is clocked on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port slowen, input, 1 bit: one-cycle enable, asserted 1 clk in every 256 by the existing divider.
REQ-004 The block SHALL have port push, input, 1 bit: one-cycle pulse for a debounced player push.
REQ-005 The block SHALL have port right, input, 1 bit: side that pushed, valid only with push; 1 = right, 0 = left.
REQ-006 The block SHALL have port pos, output, 4 bits: rope position, range 0..8, centre 4.
REQ-007 The block SHALL have port leds, output, 9 bits: LED display; one-hot of pos during play.
REQ-008 The block SHALL have port winrnd, output, 1 bit: one-clk pulse when a round is won and the game is not over; feeds the sound controller.
REQ-009 The block SHALL have port wingame, output, 1 bit: one-clk pulse when the game is won; feeds the sound controller.
REQ-010 The block SHALL have ports lscore and rscore, outputs, 2 bits each: rounds won per side, range 0..3.
REQ-011 The block SHALL have port rwon, output, 1 bit: winner of the last round or game; 1 = right.

Function
REQ-012 The FSM SHALL have exactly three states: PLAY, ROUND_END and GAME_OVER.
REQ-013 In PLAY, push with right=1 SHALL increment pos on the next clk; push with right=0 SHALL decrement it.
REQ-014 When pos becomes 8, right SHALL win the round; when pos becomes 0, left SHALL win the round.
REQ-015 When a round is won, the winner's score SHALL increment and rwon SHALL update, both in the same cycle that pos reaches the edge.
REQ-016 On a round win, if the winner's new score is below 3: winrnd SHALL pulse for exactly 1 clk, the FSM SHALL enter ROUND_END, and wingame SHALL stay 0.
REQ-017 On a round win, if the winner's new score equals 3: wingame SHALL pulse for exactly 1 clk, the FSM SHALL enter GAME_OVER, and winrnd SHALL stay 0.
REQ-018 Both pulses SHALL be registered and SHALL occur 1 clk after the edge-reaching push.
REQ-019 In ROUND_END, the block SHALL count slowen pulses; on the 16th, it SHALL set pos to 4, clear the counter and return to PLAY.
REQ-020 In ROUND_END, pos SHALL hold at the edge value and leds SHALL show one-hot pos.
REQ-021 In GAME_OVER, leds SHALL show only the winner's end LED (leds[8] for right, leds[0] for left).
REQ-022 In GAME_OVER, that LED SHALL start lit and toggle every 8 slowen pulses.
REQ-023 The block SHALL stay in GAME_OVER until rst.
REQ-024 push SHALL be ignored in ROUND_END and GAME_OVER.
REQ-025 push SHALL be ignored in PLAY whenever pos is not within 1..7.
REQ-026 push and slowen arriving in the same clk SHALL both take effect independently.
REQ-027 Scores SHALL never exceed 3; no wrap-around is permitted.

Reset
REQ-028 While rst=1, on the clk edge the block SHALL set state=PLAY, pos=4, leds=9'b000010000, lscore=0, rscore=0, rwon=0, winrnd=0, wingame=0, and clear the hold and flash counters.
REQ-029 rst SHALL take priority over push and slowen.
REQ-030 rst asserted mid-round or during ROUND_END/GAME_OVER SHALL abort to the reset state with no winrnd or wingame pulse.

Structure
REQ-031 The shared game package SHALL hold: state encoding, CENTER=4, MAX_POS=8, WIN_SCORE=3, ROUND_HOLD=16, FLASH_DIV=8.
REQ-032 One sub-module, tug_hold_timer, SHALL count slowen pulses to a parameterised terminal value, with clear input and done pulse; it SHALL be reused for both ROUND_END and GAME_OVER.

Verification
REQ-033 Reset, then 4 right pushes -> pos goes 5,6,7,8; winrnd=1 for 1 clk; rscore=1; rwon=1.
REQ-034 After REQ-033, 16 slowen pulses -> pos=4 and back in PLAY; a push during the hold leaves pos=8.
REQ-035 Left wins 3 rounds -> third win gives wingame=1 for 1 clk, winrnd=0, lscore=3; leds=9'b000000001 toggling every 8 slowen pulses; push ignored.
REQ-036 Alternating right/left pushes for 20 cycles -> pos oscillates 4,5,4; no pulses.
REQ-037 rst=1 one cycle before pos would reach 8 -> pos=4, scores 0, winrnd never asserts.
REQ-038 push and slowen in the same clk during ROUND_END -> hold counter advances, pos unchanged.
